// File: rtl/tile_plotter_pkg.sv
// Shared encodings and screen geometry for the tile plotter and its sprite logic.
package tile_plotter_pkg;

    typedef enum logic [1:0] {
        KIND_EMPTY  = 2'd0,
        KIND_WALL   = 2'd1,
        KIND_TANK   = 2'd2,
        KIND_BULLET = 2'd3
    } tile_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_FIN   = 2'd3
    } plot_state_e;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] WHITE  = 3'b111;
    localparam logic [2:0] RED    = 3'b100;

    localparam logic [7:0] TILE  = 8'd7;
    localparam logic [7:0] X_OFF = 8'd24;
    localparam logic [7:0] Y_OFF = 8'd4;
    localparam logic [7:0] SCR_W = 8'd160;
    localparam logic [7:0] SCR_H = 8'd120;

    // Screen coordinate of pixel 0 of a tile row/column; max 24+15*7 fits in 8 bits.
    function automatic logic [7:0] tile_base(input logic [3:0] idx, input logic [7:0] off);
        return off + ({4'd0, idx} * TILE);
    endfunction

endpackage

// File: rtl/tile_pixel_colour.sv
// Sprite rules: colour of one pixel of a tile given its kind and in-tile position.
module tile_pixel_colour
    import tile_plotter_pkg::*;
(
    input  tile_kind_e  kind,
    input  logic [2:0]  px,
    input  logic [2:0]  py,
    output logic [2:0]  colour
);

    logic in_core_s;

    assign in_core_s = (px >= 3'd2) && (px <= 3'd4) && (py >= 3'd2) && (py <= 3'd4);

    // Per-kind sprite lookup.
    always_comb begin
        colour = BLACK;
        case (kind)
            KIND_EMPTY:  colour = BLACK;
            KIND_WALL:   colour = YELLOW;
            KIND_TANK: begin
                if ((px == 3'd3) && (py == 3'd3)) begin
                    colour = WHITE;
                end else begin
                    colour = GREEN;
                end
            end
            KIND_BULLET: begin
                if (in_core_s) begin
                    colour = RED;
                end else begin
                    colour = BLACK;
                end
            end
            default:     colour = BLACK;
        endcase
    end

endmodule

// File: rtl/tile_plotter.sv
// Rasterises one 7x7 tile, or sweeps the whole 160x120 screen black, into the
// VGA adapter's pixel-write port at one pixel per clock.
module tile_plotter
    import tile_plotter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       clr,
    input  logic [7:0] tile_addr,
    input  logic [1:0] tile_kind,
    output logic       ready,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done
);

    plot_state_e state_r, state_s;
    logic [7:0]  cnt_x_r, cnt_x_s;
    logic [7:0]  cnt_y_r, cnt_y_s;
    logic [7:0]  base_x_r, base_x_s;
    logic [7:0]  base_y_r, base_y_s;
    tile_kind_e  kind_r, kind_s;
    logic        plot_s, done_s, ready_s;
    logic [7:0]  x_full_s, y_full_s;
    logic [2:0]  pix_colour_s;

    // Outputs are produced from the next-cycle counters so they land in registers
    // together with the state that generated them.
    assign x_full_s = base_x_s + cnt_x_s;
    assign y_full_s = base_y_s + cnt_y_s;

    tile_pixel_colour u_pix (
        .kind   (kind_s),
        .px     (cnt_x_s[2:0]),
        .py     (cnt_y_s[2:0]),
        .colour (pix_colour_s)
    );

    // Next-state, counter and output decode.
    always_comb begin
        state_s  = state_r;
        cnt_x_s  = cnt_x_r;
        cnt_y_s  = cnt_y_r;
        base_x_s = base_x_r;
        base_y_s = base_y_r;
        kind_s   = kind_r;
        plot_s   = 1'b0;
        done_s   = 1'b0;
        ready_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_FIN: begin
                // FIN also accepts, so back-to-back requests need no idle gap.
                if (clr) begin
                    state_s  = ST_CLEAR;
                    cnt_x_s  = 8'd0;
                    cnt_y_s  = 8'd0;
                    base_x_s = 8'd0;
                    base_y_s = 8'd0;
                    kind_s   = KIND_EMPTY;
                    plot_s   = 1'b1;
                end else if (req) begin
                    state_s  = ST_DRAW;
                    cnt_x_s  = 8'd0;
                    cnt_y_s  = 8'd0;
                    base_x_s = tile_base(tile_addr[3:0], X_OFF);
                    base_y_s = tile_base(tile_addr[7:4], Y_OFF);
                    kind_s   = tile_kind_e'(tile_kind);
                    plot_s   = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                    ready_s  = 1'b1;
                end
            end
            ST_DRAW: begin
                if (cnt_x_r == (TILE - 8'd1)) begin
                    if (cnt_y_r == (TILE - 8'd1)) begin
                        state_s = ST_FIN;
                        done_s  = 1'b1;
                        ready_s = 1'b1;
                    end else begin
                        cnt_x_s = 8'd0;
                        cnt_y_s = cnt_y_r + 8'd1;
                        plot_s  = 1'b1;
                    end
                end else begin
                    cnt_x_s = cnt_x_r + 8'd1;
                    plot_s  = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (cnt_x_r == (SCR_W - 8'd1)) begin
                    if (cnt_y_r == (SCR_H - 8'd1)) begin
                        state_s = ST_FIN;
                        done_s  = 1'b1;
                        ready_s = 1'b1;
                    end else begin
                        cnt_x_s = 8'd0;
                        cnt_y_s = cnt_y_r + 8'd1;
                        plot_s  = 1'b1;
                    end
                end else begin
                    cnt_x_s = cnt_x_r + 8'd1;
                    plot_s  = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                ready_s = 1'b1;
            end
        endcase
    end

    // State, counters, latched request and registered adapter outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_x_r  <= 8'd0;
            cnt_y_r  <= 8'd0;
            base_x_r <= 8'd0;
            base_y_r <= 8'd0;
            kind_r   <= KIND_EMPTY;
            ready    <= 1'b1;
            plot     <= 1'b0;
            done     <= 1'b0;
            x        <= 8'd0;
            y        <= 7'd0;
            colour   <= 3'd0;
        end else begin
            state_r  <= state_s;
            cnt_x_r  <= cnt_x_s;
            cnt_y_r  <= cnt_y_s;
            base_x_r <= base_x_s;
            base_y_r <= base_y_s;
            kind_r   <= kind_s;
            ready    <= ready_s;
            plot     <= plot_s;
            done     <= done_s;
            x        <= x_full_s;
            y        <= y_full_s[6:0];
            colour   <= pix_colour_s;
        end
    end

endmodule

// File: tb/tb_tile_plotter.sv
// Directed bench for tile_plotter: tile draws, clear sweep, back-to-back and reset abort.
module tb_tile_plotter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       clr;
    logic [7:0] tile_addr;
    logic [1:0] tile_kind;
    logic       ready;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    int n_plot, n_gap, fx, fy, lx, ly;
    int sxmin, sxmax, symin, symax;
    int done_seen, done_ready;
    int hist[8];

    always #5 clk = ~clk;

    tile_plotter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .clr       (clr),
        .tile_addr (tile_addr),
        .tile_kind (tile_kind),
        .ready     (ready),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First tick is the accept edge; collects plot statistics until done or limit.
    task automatic run_op(input int limit, input int spc, input bit hold, input int chg_at);
        n_plot = 0; n_gap = 0; done_seen = 0; done_ready = 0;
        fx = -1; fy = -1; lx = -1; ly = -1;
        sxmin = 999; sxmax = -1; symin = 999; symax = -1;
        for (int c = 0; c < 8; c++) hist[c] = 0;
        for (int i = 0; i < limit && done_seen == 0; i++) begin
            tick();
            if (i == 0 && !hold) begin
                req = 1'b0;
                clr = 1'b0;
            end
            if (plot === 1'b1) begin
                if (n_plot == 0) begin
                    fx = int'(x);
                    fy = int'(y);
                end
                lx = int'(x);
                ly = int'(y);
                hist[colour]++;
                if (int'(colour) == spc) begin
                    if (int'(x) < sxmin) sxmin = int'(x);
                    if (int'(x) > sxmax) sxmax = int'(x);
                    if (int'(y) < symin) symin = int'(y);
                    if (int'(y) > symax) symax = int'(y);
                end
                n_plot++;
                if (done === 1'b1) n_gap++;
                if (n_plot == chg_at) begin
                    tile_addr = 8'hFF;
                    tile_kind = 2'd2;
                end
            end else if (done === 1'b1) begin
                done_seen  = 1;
                done_ready = int'(ready);
            end else begin
                n_gap++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; clr = 1'b0; tile_addr = 8'h00; tile_kind = 2'd0;
        #1;
        check_eq("rst_ready", ready, 1);
        check_eq("rst_plot", plot, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_xyc", {x, 1'b0, y, colour}, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check_eq("idle_ready", ready, 1);

        // wall at tile 0,0
        req = 1'b1; tile_addr = 8'h00; tile_kind = 2'd1;
        run_op(60, -1, 1'b0, -1);
        check_eq("wall_nplot", n_plot, 49);
        check_eq("wall_gap", n_gap, 0);
        check_eq("wall_first", {fx[15:0], fy[15:0]}, {16'd24, 16'd4});
        check_eq("wall_last", {lx[15:0], ly[15:0]}, {16'd30, 16'd10});
        check_eq("wall_yellow", hist[6], 49);
        check_eq("wall_done", done_seen, 1);
        check_eq("wall_fin_ready", done_ready, 1);
        tick();
        check_eq("wall_done_pulse", done, 0);
        check_eq("wall_idle_ready", ready, 1);

        // tank at bottom-right tile
        req = 1'b1; tile_addr = 8'hFF; tile_kind = 2'd2;
        run_op(60, 7, 1'b0, -1);
        check_eq("tank_nplot", n_plot, 49);
        check_eq("tank_first", {fx[15:0], fy[15:0]}, {16'd129, 16'd109});
        check_eq("tank_last", {lx[15:0], ly[15:0]}, {16'd135, 16'd115});
        check_eq("tank_white_n", hist[7], 1);
        check_eq("tank_green_n", hist[2], 48);
        check_eq("tank_white_xy", {sxmin[15:0], symin[15:0]}, {16'd132, 16'd112});
        check_eq("tank_done", done_seen, 1);

        // bullet at row 3, column 10, requested straight from FIN
        req = 1'b1; tile_addr = 8'h3A; tile_kind = 2'd3;
        run_op(60, 4, 1'b0, -1);
        check_eq("bul_nplot", n_plot, 49);
        check_eq("bul_gap", n_gap, 0);
        check_eq("bul_first", {fx[15:0], fy[15:0]}, {16'd94, 16'd25});
        check_eq("bul_last", {lx[15:0], ly[15:0]}, {16'd100, 16'd31});
        check_eq("bul_red_n", hist[4], 9);
        check_eq("bul_black_n", hist[0], 40);
        check_eq("bul_red_x", {sxmin[15:0], sxmax[15:0]}, {16'd96, 16'd98});
        check_eq("bul_red_y", {symin[15:0], symax[15:0]}, {16'd27, 16'd29});

        // clr and req together: clear wins
        clr = 1'b1; req = 1'b1; tile_addr = 8'h00; tile_kind = 2'd1;
        run_op(19300, -1, 1'b0, -1);
        check_eq("clr_nplot", n_plot, 19200);
        check_eq("clr_gap", n_gap, 0);
        check_eq("clr_first", {fx[15:0], fy[15:0]}, {16'd0, 16'd0});
        check_eq("clr_last", {lx[15:0], ly[15:0]}, {16'd159, 16'd119});
        check_eq("clr_black", hist[0], 19200);
        check_eq("clr_done", done_seen, 1);
        tick();
        check_eq("clr_after_plot", plot, 0);
        check_eq("clr_after_done", done, 0);

        // req held, inputs changed mid-draw; next draw starts at FIN
        req = 1'b1; tile_addr = 8'h00; tile_kind = 2'd1;
        run_op(60, -1, 1'b1, 10);
        check_eq("hold_nplot", n_plot, 49);
        check_eq("hold_first", {fx[15:0], fy[15:0]}, {16'd24, 16'd4});
        check_eq("hold_last", {lx[15:0], ly[15:0]}, {16'd30, 16'd10});
        check_eq("hold_yellow", hist[6], 49);
        check_eq("hold_done", done_seen, 1);
        run_op(60, 7, 1'b0, -1);
        check_eq("b2b_nplot", n_plot, 49);
        check_eq("b2b_gap", n_gap, 0);
        check_eq("b2b_first", {fx[15:0], fy[15:0]}, {16'd129, 16'd109});
        check_eq("b2b_green", hist[2], 48);
        check_eq("b2b_white", hist[7], 1);
        tick();

        // reset after 20 pixels aborts the draw
        req = 1'b1; tile_addr = 8'h00; tile_kind = 2'd1;
        tick();
        req = 1'b0;
        repeat (19) tick();
        check_eq("abort_pre_plot", plot, 1);
        check_eq("abort_pre_x", x, 8'd29);
        #2;
        reset = 1'b1;
        #1;
        check_eq("abort_plot", plot, 0);
        check_eq("abort_ready", ready, 1);
        check_eq("abort_done", done, 0);
        tick();
        check_eq("abort_hold_done", done, 0);
        reset = 1'b0;
        tick();
        check_eq("abort_idle_done", done, 0);
        check_eq("abort_idle_plot", plot, 0);
        req = 1'b1; tile_addr = 8'h00; tile_kind = 2'd1;
        run_op(60, -1, 1'b0, -1);
        check_eq("redraw_nplot", n_plot, 49);
        check_eq("redraw_first", {fx[15:0], fy[15:0]}, {16'd24, 16'd4});
        check_eq("redraw_last", {lx[15:0], ly[15:0]}, {16'd30, 16'd10});
        check_eq("redraw_done", done_seen, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
